pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 14 +
 rtl/pipe_lu_detect.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline hazard-control types and defaults.
// Imported by the hazard controller and its load-use detector.
package pipe_hazard_ctrl_pkg;

  localparam int REG_W_DEF = 5;
  localparam int MC_W_DEF  = 4;
  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } hz_state_t;

endpackage

// File: rtl/pipe_lu_detect.sv
// Combinational load-use hazard detector.
// Flags an EX load whose destination feeds the ID instruction.
module pipe_lu_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             lu_last,
  output logic             raw,
  output logic             lu
);

  logic rs_hit;
  logic rt_hit;

  // Raw dependency, then one-shot suppression via lu_last.
  always_comb begin
    rs_hit = (ex_rt == id_rs);
    rt_hit = id_uses_rt && (ex_rt == id_rt);
    raw    = mem_read && (ex_rt != '0) && (rs_hit || rt_hit);
    lu     = raw && !lu_last;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush,
// multi-cycle EX stall FSM and saturating stall statistics.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int MC_W  = MC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ID_EX_MemRead,
  input  logic [REG_W-1:0] ID_EX_Rt,
  input  logic [REG_W-1:0] IF_ID_Rs,
  input  logic [REG_W-1:0] IF_ID_Rt,
  input  logic             IF_ID_UsesRt,
  input  logic             BranchTaken,
  input  logic             MC_Start,
  input  logic [MC_W-1:0]  MC_Len,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXWrite,
  output logic             IDEXBubble,
  output logic             IFIDFlush,
  output logic             Busy,
  output logic [CNT_W-1:0] StallCycles
);

  hz_state_t        state;
  logic [MC_W-1:0]  mc_cnt;
  logic [MC_W-1:0]  mc_load;
  logic             lu_last;
  logic             lu_raw;
  logic             lu;
  logic             in_busy;
  logic             do_br;
  logic             do_lu;

  pipe_lu_detect #(
    .REG_W (REG_W)
  ) u_lu (
    .mem_read   (ID_EX_MemRead),
    .ex_rt      (ID_EX_Rt),
    .id_rs      (IF_ID_Rs),
    .id_rt      (IF_ID_Rt),
    .id_uses_rt (IF_ID_UsesRt),
    .lu_last    (lu_last),
    .raw        (lu_raw),
    .lu         (lu)
  );

  // Mutually exclusive event qualifiers; busy masks everything.
  always_comb begin
    in_busy = (state == MC_BUSY);
    do_br   = !in_busy && BranchTaken;
    do_lu   = !in_busy && !BranchTaken && lu;
    mc_load = (MC_Len == '0) ? MC_W'(1) : MC_Len;
  end

  // Pipeline enables from current state and events.
  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IDEXWrite  = 1'b1;
    IDEXBubble = 1'b0;
    IFIDFlush  = 1'b0;
    Busy       = 1'b0;
    unique case (1'b1)
      in_busy: begin
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        IDEXWrite = 1'b0;
        Busy      = 1'b1;
      end
      do_br: begin
        IFIDFlush  = 1'b1;
        IDEXBubble = 1'b1;
      end
      do_lu: begin
        PCWrite    = 1'b0;
        IFIDWrite  = 1'b0;
        IDEXBubble = 1'b1;
      end
      default: ;
    endcase
  end

  // FSM, multi-cycle counter and one-shot load-use memory.
  // lu_last tracks the raw hazard so a held condition stalls once.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= RUN;
      mc_cnt  <= '0;
      lu_last <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          lu_last <= BranchTaken ? 1'b0 : lu_raw;
          if (MC_Start) begin
            state  <= MC_BUSY;
            mc_cnt <= mc_load;
          end
        end
        MC_BUSY: begin
          lu_last <= 1'b0;
          if (mc_cnt == MC_W'(1)) begin
            state  <= RUN;
            mc_cnt <= '0;
          end else begin
            mc_cnt <= mc_cnt - 1'b1;
          end
        end
        default: begin
          state   <= RUN;
          mc_cnt  <= '0;
          lu_last <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of cycles with the PC held.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      StallCycles <= '0;
    end else if (!PCWrite && !(&StallCycles)) begin
      StallCycles <= StallCycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// A second instance with CNT_W=4 covers counter saturation.
module tb_pipe_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       ID_EX_MemRead;
  logic [4:0] ID_EX_Rt;
  logic [4:0] IF_ID_Rs;
  logic [4:0] IF_ID_Rt;
  logic       IF_ID_UsesRt;
  logic       BranchTaken;
  logic       MC_Start;
  logic [3:0] MC_Len;

  logic        PCWrite, IFIDWrite, IDEXWrite;
  logic        IDEXBubble, IFIDFlush, Busy;
  logic [15:0] StallCycles;

  logic        PCWrite4, IFIDWrite4, IDEXWrite4;
  logic        IDEXBubble4, IFIDFlush4, Busy4;
  logic [3:0]  StallCycles4;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  pipe_hazard_ctrl dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .ID_EX_MemRead (ID_EX_MemRead),
    .ID_EX_Rt      (ID_EX_Rt),
    .IF_ID_Rs      (IF_ID_Rs),
    .IF_ID_Rt      (IF_ID_Rt),
    .IF_ID_UsesRt  (IF_ID_UsesRt),
    .BranchTaken   (BranchTaken),
    .MC_Start      (MC_Start),
    .MC_Len        (MC_Len),
    .PCWrite       (PCWrite),
    .IFIDWrite     (IFIDWrite),
    .IDEXWrite     (IDEXWrite),
    .IDEXBubble    (IDEXBubble),
    .IFIDFlush     (IFIDFlush),
    .Busy          (Busy),
    .StallCycles   (StallCycles)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
    .Clk           (Clk),
    .Reset         (Reset),
    .ID_EX_MemRead (ID_EX_MemRead),
    .ID_EX_Rt      (ID_EX_Rt),
    .IF_ID_Rs      (IF_ID_Rs),
    .IF_ID_Rt      (IF_ID_Rt),
    .IF_ID_UsesRt  (IF_ID_UsesRt),
    .BranchTaken   (BranchTaken),
    .MC_Start      (MC_Start),
    .MC_Len        (MC_Len),
    .PCWrite       (PCWrite4),
    .IFIDWrite     (IFIDWrite4),
    .IDEXWrite     (IDEXWrite4),
    .IDEXBubble    (IDEXBubble4),
    .IFIDFlush     (IFIDFlush4),
    .Busy          (Busy4),
    .StallCycles   (StallCycles4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // {PCWrite,IFIDWrite,IDEXWrite,IDEXBubble,IFIDFlush,Busy}
  function automatic logic [5:0] outs();
    return {PCWrite, IFIDWrite, IDEXWrite,
            IDEXBubble, IFIDFlush, Busy};
  endfunction

  task automatic idle_in();
    ID_EX_MemRead = 1'b0;
    ID_EX_Rt      = '0;
    IF_ID_Rs      = '0;
    IF_ID_Rt      = '0;
    IF_ID_UsesRt  = 1'b0;
    BranchTaken   = 1'b0;
    MC_Start      = 1'b0;
    MC_Len        = '0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    idle_in();
    Reset = 1'b1;
    #1;
    Reset = 1'b0;
    #1;
  endtask

  localparam logic [5:0] IDLE_O = 6'b111000;
  localparam logic [5:0] LU_O   = 6'b001100;
  localparam logic [5:0] BR_O   = 6'b111110;
  localparam logic [5:0] BUSY_O = 6'b000001;

  initial begin
    idle_in();
    Reset = 1'b1;
    #12;
    chk("reset_outs", 32'(outs()), 32'(IDLE_O));
    chk("reset_stall", 32'(StallCycles), 0);
    Reset = 1'b0;
    tick();

    // Load-use held for three cycles: one stall only.
    do_reset();
    ID_EX_MemRead = 1'b1;
    ID_EX_Rt = 5'd8;
    IF_ID_Rs = 5'd8;
    #1;
    chk("lu_c1_outs", 32'(outs()), 32'(LU_O));
    tick();
    chk("lu_c2_outs", 32'(outs()), 32'(IDLE_O));
    chk("lu_c2_stall", 32'(StallCycles), 1);
    tick();
    chk("lu_c3_outs", 32'(outs()), 32'(IDLE_O));
    tick();
    chk("lu_end_stall", 32'(StallCycles), 1);

    // Hazard via Rt only when the ID instruction reads Rt.
    do_reset();
    ID_EX_MemRead = 1'b1;
    ID_EX_Rt = 5'd9;
    IF_ID_Rs = 5'd3;
    IF_ID_Rt = 5'd9;
    #1;
    chk("lu_rt_unused", 32'(PCWrite), 1);
    IF_ID_UsesRt = 1'b1;
    #1;
    chk("lu_rt_used", 32'(outs()), 32'(LU_O));

    // Register zero never creates a hazard.
    do_reset();
    ID_EX_MemRead = 1'b1;
    #1;
    chk("rt0_outs", 32'(outs()), 32'(IDLE_O));
    tick();
    chk("rt0_stall", 32'(StallCycles), 0);

    // Branch overrides a load-use and clears lu_last.
    do_reset();
    ID_EX_MemRead = 1'b1;
    ID_EX_Rt = 5'd8;
    IF_ID_Rs = 5'd8;
    BranchTaken = 1'b1;
    #1;
    chk("br_outs", 32'(outs()), 32'(BR_O));
    tick();
    chk("br_stall", 32'(StallCycles), 0);
    BranchTaken = 1'b0;
    #1;
    chk("br_then_lu", 32'(outs()), 32'(LU_O));

    // Multi-cycle, length 5.
    do_reset();
    MC_Start = 1'b1;
    MC_Len = 4'd5;
    #1;
    chk("mc5_start", 32'(outs()), 32'(IDLE_O));
    tick();
    MC_Start = 1'b0;
    BranchTaken = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("mc5_busy%0d", i), 32'(outs()), 32'(BUSY_O));
      tick();
    end
    BranchTaken = 1'b0;
    #1;
    chk("mc5_done", 32'(outs()), 32'(IDLE_O));
    chk("mc5_stall", 32'(StallCycles), 5);

    // Multi-cycle, length 0 behaves as 1.
    do_reset();
    MC_Start = 1'b1;
    MC_Len = 4'd0;
    tick();
    MC_Start = 1'b0;
    chk("mc0_busy", 32'(outs()), 32'(BUSY_O));
    tick();
    chk("mc0_done", 32'(outs()), 32'(IDLE_O));
    chk("mc0_stall", 32'(StallCycles), 1);

    // Start together with a branch.
    do_reset();
    MC_Start = 1'b1;
    MC_Len = 4'd2;
    BranchTaken = 1'b1;
    #1;
    chk("mcbr_outs", 32'(outs()), 32'(BR_O));
    tick();
    idle_in();
    #1;
    chk("mcbr_busy", 32'(outs()), 32'(BUSY_O));

    // Asynchronous reset in the middle of a long stall.
    do_reset();
    MC_Start = 1'b1;
    MC_Len = 4'd10;
    tick();
    MC_Start = 1'b0;
    tick();
    chk("rst_mid_busy", 32'(Busy), 1);
    Reset = 1'b1;
    #1;
    chk("rst_mid_outs", 32'(outs()), 32'(IDLE_O));
    chk("rst_mid_stall", 32'(StallCycles), 0);
    Reset = 1'b0;
    tick();
    chk("rst_mid_after", 32'(Busy), 0);

    // Two 15-cycle stalls: 4-bit counter saturates.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      MC_Start = 1'b1;
      MC_Len = 4'd15;
      tick();
      MC_Start = 1'b0;
      repeat (15) tick();
      chk($sformatf("sat4_r%0d", r), 32'(StallCycles4), 15);
      chk($sformatf("sat16_r%0d", r), 32'(StallCycles),
          32'(15 * (r + 1)));
    end
    chk("sat4_idle", 32'(Busy4), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
